// File: rtl/matmul_pkg.sv
// Shared state encoding and index/width helpers for the parametrised matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mm_state_t;

  // Row-major element offset of (i,j) in an n x n matrix.
  function automatic int idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  // Accumulator width that cannot overflow for an unsaturated n-term dot product.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Combinational MAC step: o_res = i_acc + i_a*i_b, with overflow flag.
// With MATMUL_SAT_EN defined the result clamps to the ACCW range instead of wrapping.
module matmul_mac_unit #(
  parameter int DW     = 16,
  parameter int ACCW   = 35,
  parameter int SIGNED = 1
) (
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  input  logic [ACCW-1:0] i_acc,
  output logic [ACCW-1:0] o_res,
  output logic            o_ovf
);

  localparam int PW = 2 * DW;
  // Two guard bits above the wider of product/accumulator keep the sum exact.
  localparam int XW = ((PW > ACCW) ? PW : ACCW) + 2;
  localparam bit SX = (SIGNED != 0);

  logic [PW-1:0] w_a_x;
  logic [PW-1:0] w_b_x;
  logic [PW-1:0] w_prod;
  logic [XW-1:0] w_prod_x;
  logic [XW-1:0] w_acc_x;
  logic [XW-1:0] w_sum;
  logic          w_ovf;

  assign w_a_x    = {{DW{SX & i_a[DW-1]}}, i_a};
  assign w_b_x    = {{DW{SX & i_b[DW-1]}}, i_b};
  assign w_prod   = w_a_x * w_b_x;
  assign w_prod_x = {{(XW-PW){SX & w_prod[PW-1]}}, w_prod};
  assign w_acc_x  = {{(XW-ACCW){SX & i_acc[ACCW-1]}}, i_acc};
  assign w_sum    = w_prod_x + w_acc_x;

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_ovf = !((&w_sum[XW-1:ACCW-1]) || !(|w_sum[XW-1:ACCW-1]));
    end else begin : g_unsigned
      assign w_ovf = |w_sum[XW-1:ACCW];
    end
  endgenerate

`ifdef MATMUL_SAT_EN
  logic [ACCW-1:0] w_sat;

  always_comb begin
    w_sat = '1;
    if (SIGNED != 0) begin
      w_sat = w_sum[XW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end

  assign o_res = w_ovf ? w_sat : w_sum[ACCW-1:0];
`else
  assign o_res = w_sum[ACCW-1:0];
`endif

  assign o_ovf = w_ovf;

endmodule

// File: rtl/param_matrix_multiplier.sv
// N x N C = A x B (or C += A x B) on one shared MAC, k innermost, then j, then i; N^3+1 cycles start to done.
// Optional macro MATMUL_SAT_EN: saturate each MAC step instead of wrapping.
module param_matrix_multiplier
  import matmul_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 16,
  parameter int ACCW   = acc_width(DW, N),
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  acc_mode,
  input  logic [N*N*DW-1:0]     a_flat,
  input  logic [N*N*DW-1:0]     b_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  c_valid,
  output logic [N*N*ACCW-1:0]   c_flat,
  output logic                  ovf
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mm_state_t             r_state;
  mm_state_t             w_state_nxt;
  logic [N*N*DW-1:0]     r_a;
  logic [N*N*DW-1:0]     r_b;
  logic [N*N*ACCW-1:0]   r_c;
  logic [ACCW-1:0]       r_acc;
  logic [CW-1:0]         r_i;
  logic [CW-1:0]         r_j;
  logic [CW-1:0]         r_k;
  logic                  r_acc_mode;
  logic                  r_c_valid;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_elem_end;
  logic                  w_last;
  logic [DW-1:0]         w_a_el;
  logic [DW-1:0]         w_b_el;
  logic [ACCW-1:0]       w_c_cur;
  logic [ACCW-1:0]       w_acc_in;
  logic [ACCW-1:0]       w_mac_res;
  logic                  w_mac_ovf;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_elem_end = (r_k == LAST);
  assign w_last     = (r_state == CALC) && w_elem_end && (r_j == LAST) && (r_i == LAST);

  assign w_a_el  = r_a[idx(int'(r_i), int'(r_k), N)*DW +: DW];
  assign w_b_el  = r_b[idx(int'(r_k), int'(r_j), N)*DW +: DW];
  assign w_c_cur = r_c[idx(int'(r_i), int'(r_j), N)*ACCW +: ACCW];

  // First term of each element seeds from zero or the element's previous value.
  assign w_acc_in = (r_k != '0) ? r_acc : (r_acc_mode ? w_c_cur : '0);

  matmul_mac_unit #(
    .DW     (DW),
    .ACCW   (ACCW),
    .SIGNED (SIGNED)
  ) u_mac (
    .i_a   (w_a_el),
    .i_b   (w_b_el),
    .i_acc (w_acc_in),
    .o_res (w_mac_res),
    .o_ovf (w_mac_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_acc      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc_mode <= 1'b0;
      r_c_valid  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a        <= a_flat;
        r_b        <= b_flat;
        r_acc_mode <= acc_mode;
        r_c_valid  <= 1'b0;
        r_ovf      <= 1'b0;
        r_i        <= '0;
        r_j        <= '0;
        r_k        <= '0;
      end
      if (r_state == CALC) begin
        r_acc <= w_mac_res;
        if (w_mac_ovf) r_ovf <= 1'b1;
        if (w_elem_end) begin
          r_c[idx(int'(r_i), int'(r_j), N)*ACCW +: ACCW] <= w_mac_res;
          r_k <= '0;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
      if (w_last) r_c_valid <= 1'b1;
    end
  end

  assign c_flat  = r_c;
  assign c_valid = r_c_valid;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Directed bench for param_matrix_multiplier: three instances (signed/35b, unsigned/35b, signed/16b)
// checked against a range-based reference model through an expected-result queue.
module tb_param_matrix_multiplier;

  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int NE   = N * N;
  localparam int AW_D = 2 * DW + 3;
  localparam int AW_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 acc_mode;
  logic [NE*DW-1:0]     a_flat;
  logic [NE*DW-1:0]     b_flat;
  logic [2:0]           st;
  logic [2:0]           busy_v;
  logic [2:0]           done_v;
  logic [2:0]           cval_v;
  logic [2:0]           ovf_v;
  logic [NE*AW_D-1:0]   c_def;
  logic [NE*AW_D-1:0]   c_uns;
  logic [NE*AW_W-1:0]   c_w16;

  int                   ta [NE];
  int                   tbm[NE];
  longint               cur_c[3][NE];
  logic signed [63:0]   sb_q[$];
  int                   n_assert = 0;
  int                   n_fail   = 0;

  always #5 clk = ~clk;

  param_matrix_multiplier #(.N(N), .DW(DW), .SIGNED(1)) u_def (
    .clk(clk), .rst(rst), .start(st[0]), .acc_mode(acc_mode), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_v[0]), .done(done_v[0]), .c_valid(cval_v[0]), .c_flat(c_def), .ovf(ovf_v[0]));

  param_matrix_multiplier #(.N(N), .DW(DW), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .start(st[1]), .acc_mode(acc_mode), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_v[1]), .done(done_v[1]), .c_valid(cval_v[1]), .c_flat(c_uns), .ovf(ovf_v[1]));

  param_matrix_multiplier #(.N(N), .DW(DW), .ACCW(AW_W), .SIGNED(1)) u_w16 (
    .clk(clk), .rst(rst), .start(st[2]), .acc_mode(acc_mode), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_v[2]), .done(done_v[2]), .c_valid(cval_v[2]), .c_flat(c_w16), .ovf(ovf_v[2]));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] get_c(input int w, input int e);
    logic signed [AW_D-1:0] sd;
    logic [AW_D-1:0]        ud;
    logic signed [AW_W-1:0] sw;
    sd = c_def[e*AW_D +: AW_D];
    ud = c_uns[e*AW_D +: AW_D];
    sw = c_w16[e*AW_W +: AW_W];
    if (w == 0) return sd;
    if (w == 1) return {{(64-AW_D){1'b0}}, ud};
    return sw;
  endfunction

  function automatic longint sval(input int v, input bit sgn);
    if (sgn && v[DW-1]) return longint'(v) - (longint'(1) << DW);
    return longint'(v);
  endfunction

  task automatic load();
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = ta[e][DW-1:0];
      b_flat[e*DW +: DW] = tbm[e][DW-1:0];
    end
  endtask

  // Reference: exact integer sums, clamped or wrapped into the accumulator range after every term.
  task automatic model(input int w, input bit mode, output bit eovf);
    longint accw, m, lo, hi, acc, s;
    bit     sgn, sat;
    sgn  = (w != 1);
    accw = (w == 2) ? AW_W : AW_D;
    sat  = 1'b0;
`ifdef MATMUL_SAT_EN
    sat  = 1'b1;
`endif
    m    = longint'(1) << accw;
    lo   = sgn ? -(m / 2) : 0;
    hi   = sgn ? (m / 2 - 1) : (m - 1);
    eovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = mode ? cur_c[w][i*N+j] : 0;
        for (int k = 0; k < N; k++) begin
          s = acc + sval(ta[i*N+k], sgn) * sval(tbm[k*N+j], sgn);
          if (s < lo || s > hi) begin
            eovf = 1'b1;
            if (sat) s = (s < lo) ? lo : hi;
            else begin
              s = s & (m - 1);
              if (s > hi) s = s - m;
            end
          end
          acc = s;
        end
        cur_c[w][i*N+j] = acc;
        sb_q.push_back(acc);
      end
    end
  endtask

  task automatic run(input int w, input bit mode, input int pulse_at, input int rst_at,
                     output int lat, output int bcnt);
    acc_mode = mode;
    lat      = -1;
    bcnt     = 0;
    st[w]    = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 700; c++) begin
      if (c == 1) begin
        chk("c_valid_cleared_by_start", cval_v[w], 0);
        chk("ovf_cleared_by_start", ovf_v[w], 0);
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("abort_busy", busy_v[w], 0);
        chk("abort_c_valid", cval_v[w], 0);
        chk("abort_c_flat_zero", |c_def, 0);
      end
      if (busy_v[w]) bcnt++;
      if (done_v[w]) begin
        lat = c;
        break;
      end
      st[w] = (c == pulse_at);
      rst   = (rst_at > 0 && c == rst_at);
      @(negedge clk);
    end
    st[w] = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic finish_run(input int w, input string tag, input int lat, input int bcnt, input bit eovf);
    chk({tag, "_latency"}, lat, N*N*N + 1);
    chk({tag, "_busy_cycles"}, bcnt, N*N*N + 1);
    chk({tag, "_c_valid_at_done"}, cval_v[w], 1);
    chk({tag, "_ovf"}, ovf_v[w], eovf);
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, done_v[w], 0);
    chk({tag, "_busy_after"}, busy_v[w], 0);
    chk({tag, "_c_valid_holds"}, cval_v[w], 1);
    for (int e = 0; e < NE; e++) begin
      chk($sformatf("%s_c[%0d]", tag, e), get_c(w, e), sb_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;
    bit eovf;
    for (int w = 0; w < 3; w++) for (int e = 0; e < NE; e++) cur_c[w][e] = 0;
    rst = 1'b1; st = '0; acc_mode = 1'b0; a_flat = '0; b_flat = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_v[0], 0);
    chk("reset_done", done_v[0], 0);
    chk("reset_c_valid", cval_v[0], 0);
    chk("reset_ovf", ovf_v[0], 0);
    chk("reset_c_flat", |c_def, 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity x B gives B back.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      ta[i*N+j] = (i == j) ? 1 : 0;
      tbm[i*N+j] = i * 8 + j;
    end
    load();
    model(0, 1'b0, eovf);
    run(0, 1'b0, 0, 0, lat, bcnt);
    finish_run(0, "ident", lat, bcnt, eovf);
    chk("ident_c77_is_b77", get_c(0, 63), 63);

    // A=i+j, B=i*j, with a start pulse mid-run that must be ignored.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      ta[i*N+j] = i + j;
      tbm[i*N+j] = i * j;
    end
    load();
    model(0, 1'b0, eovf);
    run(0, 1'b0, 50, 0, lat, bcnt);
    finish_run(0, "mul", lat, bcnt, eovf);
    chk("mul_c12", get_c(0, 1*N+2), 336);
    chk("mul_c77", get_c(0, 63), 2352);

    model(0, 1'b1, eovf);
    run(0, 1'b1, 0, 0, lat, bcnt);
    finish_run(0, "acc", lat, bcnt, eovf);
    chk("acc_c12", get_c(0, 1*N+2), 672);
    chk("acc_c77", get_c(0, 63), 4704);

    // All 0xFFFF times all 2: signed -16, unsigned 1048560.
    for (int e = 0; e < NE; e++) begin
      ta[e] = 16'hFFFF;
      tbm[e] = 2;
    end
    load();
    model(0, 1'b0, eovf);
    run(0, 1'b0, 0, 0, lat, bcnt);
    finish_run(0, "neg_signed", lat, bcnt, eovf);
    chk("neg_signed_c00", get_c(0, 0), -16);
    model(1, 1'b0, eovf);
    run(1, 1'b0, 0, 0, lat, bcnt);
    finish_run(1, "unsigned", lat, bcnt, eovf);
    chk("unsigned_c77", get_c(1, 63), 1048560);

    // 16-bit accumulator with 0x7FFF squared: overflow on every step.
    for (int e = 0; e < NE; e++) begin
      ta[e] = 16'h7FFF;
      tbm[e] = 16'h7FFF;
    end
    load();
    model(2, 1'b0, eovf);
    run(2, 1'b0, 0, 0, lat, bcnt);
    finish_run(2, "narrow", lat, bcnt, eovf);
    chk("narrow_ovf_set", ovf_v[2], 1);
`ifdef MATMUL_SAT_EN
    chk("narrow_c00_saturated", get_c(2, 0), 32767);
`else
    chk("narrow_c00_wrapped", get_c(2, 0), 8);
`endif

    // Reset at T+100 aborts; no done may follow.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      ta[i*N+j] = i + j;
      tbm[i*N+j] = i * j;
    end
    load();
    run(0, 1'b0, 0, 100, lat, bcnt);
    chk("abort_no_done", lat, -1);
    chk("abort_ovf", ovf_v[0], 0);
    for (int w = 0; w < 3; w++) for (int e = 0; e < NE; e++) cur_c[w][e] = 0;

    // Accumulate after reset starts from a cleared C.
    model(0, 1'b1, eovf);
    run(0, 1'b1, 0, 0, lat, bcnt);
    finish_run(0, "post_rst", lat, bcnt, eovf);
    chk("post_rst_c12", get_c(0, 1*N+2), 336);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
